// File: rtl/term_ctrl.sv
// Text-terminal controller: turns received bytes into VRAM cell writes, cursor moves, scroll and clear.
// Build option: define TERM_AUTOWRAP_EN to wrap printing at the last column into a line-feed.
`timescale 1ns/1ps

module term_ctrl #(
    parameter int COLS = 60,
    parameter int ROWS = 17
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_vram_din,
    input  logic [7:0]  i_vram_dout,
    output logic        o_vram_ce,
    output logic        o_vram_wre,
    output logic [4:0]  o_cursor_row,
    output logic [5:0]  o_cursor_col,
    output logic        o_busy,
    output logic [2:0]  o_dbg_state
);

    // Handshake: a byte is consumed on a rising edge where i_rx_valid && o_rx_ready;
    // the sender keeps i_rx_data stable until then, and o_rx_ready is high only in IDLE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_SCROLL_RD = 3'd2,
        ST_SCROLL_WR = 3'd3,
        ST_CLEAR     = 3'd4
    } state_t;

    localparam logic [5:0] LAST_COL    = 6'(COLS - 1);
    localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
    localparam logic [4:0] SCROLL_LAST = 5'(ROWS - 2);

    state_t     r_state;
    logic       r_run;
    logic [4:0] r_row;
    logic [5:0] r_col;
    logic [4:0] r_scan_row;
    logic [5:0] r_scan_col;
    logic [7:0] r_data;
    logic       r_home;

    state_t     w_state;
    logic [4:0] w_row;
    logic [5:0] w_col;
    logic [4:0] w_scan_row;
    logic [5:0] w_scan_col;
    logic [7:0] w_data;
    logic       w_home;
    logic       w_accept;
    logic [4:0] w_src_row;
    logic       w_ce;
    logic       w_wre;
    logic [10:0] w_addr;
    logic [7:0] w_din;

    assign w_accept  = (r_state == ST_IDLE) && r_run && i_rx_valid;
    assign w_src_row = r_scan_row + 5'd1;

    always_comb begin
        w_state    = r_state;
        w_row      = r_row;
        w_col      = r_col;
        w_scan_row = r_scan_row;
        w_scan_col = r_scan_col;
        w_data     = r_data;
        w_home     = r_home;
        w_ce       = 1'b0;
        w_wre      = 1'b0;
        w_addr     = 11'd0;
        w_din      = 8'd0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_rx_data >= 8'h20 && i_rx_data <= 8'h7E) begin
                        w_data  = i_rx_data;
                        w_state = ST_WRITE;
                    end else if (i_rx_data == 8'h0D) begin
                        w_col = 6'd0;
                    end else if (i_rx_data == 8'h0A) begin
                        if (r_row < LAST_ROW) begin
                            w_row = r_row + 5'd1;
                        end else begin
                            w_state    = ST_SCROLL_RD;
                            w_scan_row = 5'd0;
                            w_scan_col = 6'd0;
                        end
                    end else if (i_rx_data == 8'h08) begin
                        if (r_col != 6'd0) begin
                            w_col = r_col - 6'd1;
                        end
                    end else if (i_rx_data == 8'h0C) begin
                        w_state    = ST_CLEAR;
                        w_scan_row = 5'd0;
                        w_scan_col = 6'd0;
                        w_home     = 1'b1;
                    end
                end
            end

            ST_WRITE: begin
                w_ce    = 1'b1;
                w_wre   = 1'b1;
                w_addr  = {r_row, r_col};
                w_din   = r_data;
                w_state = ST_IDLE;
                if (r_col < LAST_COL) begin
                    w_col = r_col + 6'd1;
                end else begin
`ifdef TERM_AUTOWRAP_EN
                    w_col = 6'd0;
                    if (r_row < LAST_ROW) begin
                        w_row = r_row + 5'd1;
                    end else begin
                        w_state    = ST_SCROLL_RD;
                        w_scan_row = 5'd0;
                        w_scan_col = 6'd0;
                    end
`else
                    w_col = r_col;
`endif
                end
            end

            // Read one row below, write it back one row up on the following cycle.
            ST_SCROLL_RD: begin
                w_ce    = 1'b1;
                w_addr  = {w_src_row, r_scan_col};
                w_state = ST_SCROLL_WR;
            end

            ST_SCROLL_WR: begin
                w_ce    = 1'b1;
                w_wre   = 1'b1;
                w_addr  = {r_scan_row, r_scan_col};
                w_din   = i_vram_dout;
                w_state = ST_SCROLL_RD;
                if (r_scan_col == LAST_COL) begin
                    w_scan_col = 6'd0;
                    if (r_scan_row == SCROLL_LAST) begin
                        w_state    = ST_CLEAR;
                        w_scan_row = LAST_ROW;
                        w_home     = 1'b0;
                    end else begin
                        w_scan_row = r_scan_row + 5'd1;
                    end
                end else begin
                    w_scan_col = r_scan_col + 6'd1;
                end
            end

            // Shared by form-feed (whole screen, then home) and scroll (last row only).
            ST_CLEAR: begin
                w_ce   = 1'b1;
                w_wre  = 1'b1;
                w_addr = {r_scan_row, r_scan_col};
                if (r_scan_col == LAST_COL) begin
                    w_scan_col = 6'd0;
                    if (r_scan_row == LAST_ROW) begin
                        w_state = ST_IDLE;
                        if (r_home) begin
                            w_row  = 5'd0;
                            w_col  = 6'd0;
                            w_home = 1'b0;
                        end
                    end else begin
                        w_scan_row = r_scan_row + 5'd1;
                    end
                end else begin
                    w_scan_col = r_scan_col + 6'd1;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_run      <= 1'b0;
            r_row      <= 5'd0;
            r_col      <= 6'd0;
            r_scan_row <= 5'd0;
            r_scan_col <= 6'd0;
            r_data     <= 8'd0;
            r_home     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_run      <= 1'b1;
            r_row      <= w_row;
            r_col      <= w_col;
            r_scan_row <= w_scan_row;
            r_scan_col <= w_scan_col;
            r_data     <= w_data;
            r_home     <= w_home;
        end
    end

    assign o_rx_ready   = (r_state == ST_IDLE) && r_run;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_vram_ce    = w_ce;
    assign o_vram_wre   = w_wre;
    assign o_vram_addr  = w_addr;
    assign o_vram_din   = w_din;
    assign o_cursor_row = r_row;
    assign o_cursor_col = r_col;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_term_ctrl.sv
// Bench for term_ctrl: directed byte stream, VRAM model, write scoreboard fed by the stimulus side.
`timescale 1ns/1ps

module tb_term_ctrl;
  localparam int COLS = 60;
  localparam int ROWS = 17;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [10:0] vram_addr;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout = 8'd0;
  logic        vram_ce;
  logic        vram_wre;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic        busy;
  logic [2:0]  dbg_state;

  always #21 clk = ~clk;

  term_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_vram_addr(vram_addr), .o_vram_din(vram_din), .i_vram_dout(vram_dout),
    .o_vram_ce(vram_ce), .o_vram_wre(vram_wre),
    .o_cursor_row(cursor_row), .o_cursor_col(cursor_col),
    .o_busy(busy), .o_dbg_state(dbg_state)
  );

  // ---------------- VRAM model (1-cycle read latency) ----------------
  logic [7:0] vram [0:2047];
  logic [7:0] exp_mem [0:2047];

  always @(posedge clk) begin
    if (vram_ce) begin
      if (vram_wre) vram[vram_addr] <= vram_din;
      else vram_dout <= vram[vram_addr];
    end
  end

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  int n_cmp = 0;
  int n_fail = 0;
  int rd_count = 0;
  int exp_reads = 0;
  int idle_bad = 0;
  int exp_row = 0;
  int exp_col = 0;

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic void push_wr(input int r, input int c, input logic [7:0] d);
    logic [10:0] a;
    a = {5'(r), 6'(c)};
    exp_q.push_back({a, d});
    exp_mem[a] = d;
  endfunction

  function automatic void push_scroll();
    for (int r = 0; r < ROWS - 1; r++)
      for (int c = 0; c < COLS; c++) begin
        push_wr(r, c, exp_mem[{5'(r + 1), 6'(c)}]);
        exp_reads++;
      end
    for (int c = 0; c < COLS; c++) push_wr(ROWS - 1, c, 8'h00);
  endfunction

  // Expected VRAM writes for one byte, from the terminal's visible behaviour.
  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push_wr(exp_row, exp_col, b);
      if (exp_col < COLS - 1) exp_col++;
      else begin
`ifdef TERM_AUTOWRAP_EN
        exp_col = 0;
        if (exp_row < ROWS - 1) exp_row++;
        else push_scroll();
`endif
      end
    end else if (b == 8'h0D) exp_col = 0;
    else if (b == 8'h0A) begin
      if (exp_row < ROWS - 1) exp_row++;
      else push_scroll();
    end else if (b == 8'h08) begin
      if (exp_col > 0) exp_col--;
    end else if (b == 8'h0C) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) push_wr(r, c, 8'h00);
      exp_row = 0;
      exp_col = 0;
    end
  endfunction

  // Monitor: every VRAM write is popped and compared against the queue.
  always @(negedge clk) begin
    if (vram_ce && vram_wre) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL vram_wr: got unexpected write addr=%h din=%h", vram_addr, vram_din);
      end else begin
        mon_e = exp_q.pop_front();
        if ({vram_addr, vram_din} !== mon_e) begin
          n_fail++;
          $display("FAIL vram_wr: got addr=%h din=%h expected addr=%h din=%h",
                   vram_addr, vram_din, mon_e[18:8], mon_e[7:0]);
        end
      end
    end
    if (vram_ce && !vram_wre) rd_count++;
    if (!vram_ce && (vram_wre || vram_addr != 11'd0 || vram_din != 8'd0)) idle_bad++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic [7:0] b);
    int guard;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    guard = 0;
    while (!rx_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("accept_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int exp_lat, input string name);
    int lat;
    int busy_bad;
    model_byte(b);
    drive_accept(b);
    lat = 1;
    busy_bad = 0;
    while (!rx_ready && lat < 5000) begin
      if (!busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    check(name, lat, exp_lat);
    if (exp_lat > 1) check({name, "_busy"}, busy_bad, 0);
  endtask

  task automatic check_cursor(input int r, input int c, input string name);
    check({name, "_row"}, cursor_row, r);
    check({name, "_col"}, cursor_col, c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int diffs;
    for (int i = 0; i < 2048; i++) begin
      vram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end

    repeat (3) @(negedge clk);
    check("rst_ready", rx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_ce", vram_ce, 0);
    check_cursor(0, 0, "rst_cursor");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", rx_ready, 1);

    send_byte(8'h41, 2, "lat_A");
    check_cursor(0, 1, "after_A");
    send_byte(8'h42, 2, "lat_B");
    send_byte(8'h43, 2, "lat_C");
    send_byte(8'h08, 1, "lat_bs");
    check_cursor(0, 2, "after_bs");
    send_byte(8'h78, 2, "lat_x");
    send_byte(8'h0D, 1, "lat_cr");
    check_cursor(0, 0, "after_cr");
    send_byte(8'h0A, 1, "lat_lf");
    check_cursor(1, 0, "after_lf");
    send_byte(8'h01, 1, "lat_other");
    check_cursor(1, 0, "after_other");

    send_byte(8'h0C, 1021, "lat_ff");
    check_cursor(0, 0, "after_ff");

    repeat (3) send_byte(8'h0A, 1, "lat_lf3");
    send_byte(8'h08, 1, "lat_bs_col0");
    send_byte(8'h0D, 1, "lat_cr_col0");
    check_cursor(3, 0, "row3_bs_cr");

    repeat (13) send_byte(8'h0A, 1, "lat_lf13");
    check_cursor(16, 0, "row16");
    for (int c = 0; c < 59; c++) send_byte(8'(8'h21 + c), 2, "lat_fill");
    check_cursor(16, 59, "last_cell");

`ifdef TERM_AUTOWRAP_EN
    send_byte(8'h42, 1982, "lat_wrap_scroll");
    check_cursor(16, 0, "after_wrap");
    send_byte(8'h0A, 1981, "lat_lf_scroll");
    check_cursor(16, 0, "after_lf_scroll");
    check("row14_col59", vram[{5'd14, 6'd59}], 8'h42);
    check("row14_col0", vram[{5'd14, 6'd0}], 8'h21);
`else
    send_byte(8'h42, 2, "lat_nowrap");
    check_cursor(16, 59, "after_nowrap");
    send_byte(8'h0A, 1981, "lat_lf_scroll");
    check_cursor(16, 59, "after_lf_scroll");
    check("row15_col0", vram[{5'd15, 6'd0}], 8'h21);
    check("row15_col59", vram[{5'd15, 6'd59}], 8'h42);
`endif
    check("row16_col5", vram[{5'd16, 6'd5}], 8'h00);

    diffs = 0;
    for (int i = 0; i < 2048; i++) if (vram[i] !== exp_mem[i]) diffs++;
    check("vram_image", diffs, 0);
    check("vram_reads", rd_count, exp_reads);
    check("exp_q_drained", exp_q.size(), 0);

    // Reset in the middle of a scroll: writes stop, cursor homes.
    model_byte(8'h0A);
    drive_accept(8'h0A);
    repeat (300) @(negedge clk);
    check("midscroll_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("abort_ce", vram_ce, 0);
    check("abort_wre", vram_wre, 0);
    check("abort_addr", vram_addr, 0);
    check("abort_din", vram_din, 0);
    check("abort_ready", rx_ready, 0);
    check_cursor(0, 0, "abort_cursor");
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_ready_again", rx_ready, 1);
    repeat (50) @(negedge clk);
    check("abort_idle", busy, 0);
    check("idle_vram_zero", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/term_ctrl.md
TERM_CTRL -- requirements
Module: term_ctrl

Interface
REQ-001 Parameter COLS, default 60, number of text columns (col 0..COLS-1).
REQ-002 Parameter ROWS, default 17, number of text rows (row 0..ROWS-1).
REQ-003 i_clk  input  1  system clock (24 MHz), all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset: one clock; reset is synchronous and active-low.
REQ-005 i_rx_data  input  8  received byte from the UART receiver.
REQ-006 i_rx_valid  input  1  i_rx_data valid; held with data stable until accepted.
REQ-007 o_rx_ready  output  1  byte accepted on a cycle with i_rx_valid & o_rx_ready.
REQ-008 o_vram_addr  output  11  VRAM address {row[4:0], col[5:0]}.
REQ-009 o_vram_din  output  8  VRAM write data.
REQ-010 i_vram_dout  input  8  VRAM read data, valid the cycle after a read (ce=1, wre=0).
REQ-011 o_vram_ce / o_vram_wre  output  1 each  VRAM clock enable / write(1) or read(0).
REQ-012 o_cursor_row  output  5, o_cursor_col  output  6: current cursor position for the text renderer.
REQ-013 o_busy  output  1  high in every state except IDLE.

Function
REQ-014 States: IDLE, WRITE, SCROLL_RD, SCROLL_WR, CLEAR; o_rx_ready = 1 only in IDLE.
REQ-015 Printable byte 0x20-0x7E: IDLE -> WRITE; in WRITE drive ce=1, wre=1, addr {cursor}, din=byte for exactly one cycle, then advance cursor and return to IDLE (2 cycles per character).
REQ-016 Advance: col<COLS-1 -> col+1; col=COLS-1 -> col=0 and line-feed per REQ-018.
REQ-017 0x0D (CR): col=0 and stay in IDLE, no VRAM access, ready again next cycle.
REQ-018 0x0A (LF): row<ROWS-1 -> row+1; row=ROWS-1 -> enter SCROLL_RD with row unchanged; col unchanged by LF.
REQ-019 0x08 (BS): col>0 -> col-1, no erase; col=0 -> no change.
REQ-020 0x0C (FF): enter CLEAR over all ROWS*COLS cells; cursor to (0,0) on exit.
REQ-021 Any other byte: accepted and discarded, no state change.
REQ-022 Scroll: for r=0..ROWS-2, c=0..COLS-1: SCROLL_RD reads (r+1,c), next SCROLL_WR writes that data to (r,c); then CLEAR writes 0x00 to every cell of row ROWS-1; total 2*COLS*(ROWS-1)+COLS cycles (1980 at defaults).
REQ-023 CLEAR writes 0x00 one cell per cycle, column fastest; the cursor holds its value throughout a scroll.
REQ-024 Outside VRAM-access cycles, o_vram_ce=0, o_vram_wre=0, o_vram_addr and o_vram_din hold 0.
REQ-025 i_rx_valid while busy: not accepted; the byte is taken on the first IDLE cycle.
REQ-026 Cursor coordinates never exceed COLS-1 / ROWS-1; all address arithmetic is width-exact with no wrap into other rows.

Reset
REQ-027 With i_rst_n=0 at a clock edge: state=IDLE, cursor=(0,0), o_rx_ready=0, o_busy=0, all VRAM outputs 0.
REQ-028 o_rx_ready=1 from the first cycle after reset is released.
REQ-029 Reset during WRITE/SCROLL/CLEAR aborts immediately; no further VRAM writes occur and the partially updated VRAM is left as is.

Configuration
REQ-030 Macro TERM_AUTOWRAP_EN defined: the column wrap of REQ-016 is active.
REQ-031 Macro TERM_AUTOWRAP_EN undefined: a printable byte at col=COLS-1 writes that cell and the cursor stays there; no implicit line-feed or scroll.

Verification
REQ-032 Reset, then send "A" (0x41) -> one write at addr 0 with din 0x41; cursor (0,1); ready again 2 cycles after acceptance.
REQ-033 Cursor (16,59), send 0x42 with TERM_AUTOWRAP_EN -> write at {16,59}, then 1980-cycle scroll; row 15 holds former row 16; row 16 all 0x00; cursor (16,0).
REQ-034 Same as REQ-033 without TERM_AUTOWRAP_EN -> single write at {16,59}, no scroll, cursor (16,59).
REQ-035 Send 0x0C -> 1020 consecutive writes of 0x00 covering all cells; cursor (0,0); o_busy high throughout.
REQ-036 Cursor (3,0), send 0x08 then 0x0D -> cursor stays (3,0); no VRAM access; each byte accepted in one cycle.
REQ-037 Assert i_rst_n=0 mid-scroll for one cycle -> VRAM outputs 0 next cycle; cursor (0,0); no further writes.
